id_npc_ctrl: RTL and testbench
==============================

# id_npc_ctrl

Next-PC controller for the pipelined core. It owns the fetch PC register and consumes the ID-stage branch compare code (`branch`: EQ/LT/GT) together with the decoded branch type. Each cycle it picks the next fetch address: sequential, taken branch/jump target, or trap vector. On a redirect it squashes the IF/ID register, and it keeps a taken-redirect counter and an exception PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset
- TRAP_VEC, 32'h0000_0100, target on misaligned branch/jump target
- CNT_W, 16, width of taken-redirect counter

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard-unit stall: hold PC, suppress resolution
- id_valid  in  1  ID holds a real (non-bubble) instruction
- id_br_type  in  3  0 NONE, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 JAL, 6 JALR, 7 reserved (treated as NONE)
- id_pc  in  32  PC of the ID instruction
- id_imm  in  32  sign-extended branch/jump offset
- id_rs1  in  32  forwarded rs1 value (JALR base)
- branch  in  2  ID compare code: EQ=2'b00, LT=2'b01, GT=2'b10 (shared defines); signed rs1 vs rs2
- pc  out  32  current fetch address
- fetch_valid  out  1  fetch address is valid this cycle
- if_id_flush  out  1  IF/ID captures a bubble at the next edge
- exc  out  1  one-cycle misaligned-target pulse
- epc  out  32  id_pc of the last faulting instruction
- redir_cnt  out  CNT_W  count of taken redirects

## Operation
- FSM states: BOOT, RUN, TRAP.
  - BOOT: entered on reset. fetch_valid=0 and pc=RESET_PC. Goes to RUN unconditionally on the next edge; pc does not advance.
  - RUN: normal operation, fetch_valid=1.
  - TRAP: one cycle, fetch_valid=1, pc=TRAP_VEC, resolution suppressed. Goes to RUN.
- Resolution applies only when state=RUN, id_valid=1 and stall=0.
- Taken decision:
  - BEQ: branch==EQ
  - BNE: branch!=EQ
  - BLT: branch==LT
  - BGE: branch!=LT
  - JAL and JALR: always taken
  - NONE and reserved: never taken
  - branch=2'b11 counts as neither EQ nor LT.
- Target computation, all 32-bit modulo 2^32 with carry dropped:
  - BEQ, BNE, BLT, BGE, JAL: id_pc+id_imm
  - JALR: (id_rs1+id_imm) with bit0 cleared
- Taken with target[1:0]==0:
  - if_id_flush=1
  - pc<=target
  - redir_cnt<=redir_cnt+1, wrapping at 2^CNT_W
- Taken with target[1:0]!=0:
  - if_id_flush=1
  - exc=1 (combinational, same cycle)
  - epc<=id_pc
  - pc<=TRAP_VEC
  - state<=TRAP
  - redir_cnt unchanged
- Not taken: pc<=pc+4 (wraps 32'hFFFF_FFFC→0), if_id_flush=0.
- stall=1: pc, state, epc and redir_cnt hold. if_id_flush=0 and exc=0, even when ID holds a taken branch. Resolution happens on the first unstalled cycle.
- In RUN with no resolution (id_valid=0): pc<=pc+4.

## Timing
- Reset, asynchronous on rst_n low:
  - pc=RESET_PC, state=BOOT, epc=0, redir_cnt=0
  - fetch_valid=0, if_id_flush=0, exc=0
- if_id_flush and exc are combinational from ID inputs and state. They assert in the resolving cycle so that the IF/ID register and the exception logic sample them at the same edge that loads the new pc.
- Redirect latency: branch resolved in cycle t, target fetched in cycle t+1, one wrong-path slot squashed.
- The bubble after a redirect arrives in ID with id_valid=0. No double redirect is possible.
- Reset asserted mid-redirect or mid-TRAP: the reset state wins immediately and no pending redirect survives.
- Deassertion of rst_n is synchronized externally; the block needs no extra guard.

## Test plan
- Reset/boot: rst_n low then high.
  - Required: pc=0, fetch_valid=0 for one cycle, then pc=0 with fetch_valid=1.
  - Required: pc=4 and 8 on the following cycles.
- BEQ taken: id_pc=32'h20, id_imm=32'hFFFF_FFF0, branch=EQ.
  - Required: if_id_flush=1 that cycle, next pc=32'h10, redir_cnt=1.
- BLT not taken, then BGE taken: both with branch=GT and id_pc=32'h40, imm=8.
  - Required for BLT: pc increments by 4, flush=0.
  - Required for BGE: pc=32'h48.
- JALR alignment and trap: JALR with id_rs1=32'h101 and imm=0 clears bit0.
  - Required: target 32'h100, no exc.
  - Then JAL with imm=2 at id_pc=32'h80. Required: exc=1, epc=32'h80, next pc=TRAP_VEC, one TRAP cycle, then RUN.
- Stall interaction: taken BNE held with stall=1 for 3 cycles.
  - Required: pc frozen, flush=0 throughout.
  - On the stall=0 cycle: flush=1, and redirect on the next edge.
- Wrap and counter: pc reaches 32'hFFFF_FFFC and increments to 0.
  - With CNT_W=4, 16 taken branches return redir_cnt to 0.

Source files
------------

// File: rtl/id_npc_ctrl_if.sv
// rtl/id_npc_ctrl_if.sv - ID-stage resolution inputs and fetch-side outputs of the next-PC controller
interface id_npc_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             id_valid;
    logic [2:0]       id_br_type;
    logic [31:0]      id_pc;
    logic [31:0]      id_imm;
    logic [31:0]      id_rs1;
    logic [1:0]       branch;
    logic [31:0]      pc;
    logic             fetch_valid;
    logic             if_id_flush;
    logic             exc;
    logic [31:0]      epc;
    logic [CNT_W-1:0] redir_cnt;

    modport master (
        output stall, id_valid, id_br_type, id_pc, id_imm, id_rs1, branch,
        input  pc, fetch_valid, if_id_flush, exc, epc, redir_cnt
    );

    modport slave (
        input  stall, id_valid, id_br_type, id_pc, id_imm, id_rs1, branch,
        output pc, fetch_valid, if_id_flush, exc, epc, redir_cnt
    );
endinterface

// File: rtl/id_npc_ctrl.sv
// rtl/id_npc_ctrl.sv - fetch PC register, branch/jump resolution, redirect flush and misaligned-target trap
module id_npc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int          CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    id_npc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_LT = 2'b01;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_pc, w_pc_nxt;
    logic [31:0]      r_epc, w_epc_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_taken;
    logic [31:0]      w_target;
    logic [31:0]      w_jalr_sum;
    logic             w_flush;
    logic             w_exc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_epc   <= 32'h0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_epc   <= w_epc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Compare code 2'b11 matches neither EQ nor LT, so BNE/BGE see it as taken.
    always_comb begin
        w_taken    = 1'b0;
        w_jalr_sum = bus.id_rs1 + bus.id_imm;
        w_target   = bus.id_pc + bus.id_imm;
        case (bus.id_br_type)
            3'd1:    w_taken = (bus.branch == CMP_EQ);
            3'd2:    w_taken = (bus.branch != CMP_EQ);
            3'd3:    w_taken = (bus.branch == CMP_LT);
            3'd4:    w_taken = (bus.branch != CMP_LT);
            3'd5:    w_taken = 1'b1;
            3'd6: begin
                w_taken  = 1'b1;
                w_target = {w_jalr_sum[31:1], 1'b0};
            end
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
        w_cnt_nxt   = r_cnt;
        w_flush     = 1'b0;
        w_exc       = 1'b0;
        case (r_state)
            BOOT: w_state_nxt = RUN;
            RUN: begin
                if (!bus.stall) begin
                    if (bus.id_valid && w_taken) begin
                        w_flush = 1'b1;
                        if (w_target[1:0] == 2'b00) begin
                            w_pc_nxt  = w_target;
                            w_cnt_nxt = r_cnt + 1'b1;
                        end else begin
                            w_exc       = 1'b1;
                            w_epc_nxt   = bus.id_pc;
                            w_pc_nxt    = TRAP_VEC;
                            w_state_nxt = TRAP;
                        end
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
            end
            TRAP: begin
                // The vector itself is fetched this cycle; continue sequentially after it.
                if (!bus.stall) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    assign bus.pc          = r_pc;
    assign bus.fetch_valid = (r_state != BOOT);
    assign bus.if_id_flush = w_flush;
    assign bus.exc         = w_exc;
    assign bus.epc         = r_epc;
    assign bus.redir_cnt   = r_cnt;
endmodule

// File: tb/tb_id_npc_ctrl.sv
// tb/tb_id_npc_ctrl.sv - directed self-checking bench for id_npc_ctrl
module tb_id_npc_ctrl;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    id_npc_ctrl_if #(.CNT_W(CNT_W)) bus ();

    id_npc_ctrl #(
        .RESET_PC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] p,
                         input logic [31:0] imm, input logic [31:0] rs1, input logic [1:0] cmp);
        bus.id_valid   = v;
        bus.id_br_type = t;
        bus.id_pc      = p;
        bus.id_imm     = imm;
        bus.id_rs1     = rs1;
        bus.branch     = cmp;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", bus.pc, 32'h0); end
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b exp 0", bus.fetch_valid); end
        checks++; if (bus.if_id_flush !== 1'b0 || bus.exc !== 1'b0) begin errors++; $display("FAIL reset_flush_exc got %b%b exp 00", bus.if_id_flush, bus.exc); end
        checks++; if (bus.redir_cnt !== 4'd0 || bus.epc !== 32'h0) begin errors++; $display("FAIL reset_cnt_epc got %h %h exp 0 0", bus.redir_cnt, bus.epc); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.fetch_valid !== 1'b0 || bus.pc !== 32'h0) begin errors++; $display("FAIL boot got fv=%b pc=%h exp fv=0 pc=0", bus.fetch_valid, bus.pc); end
        tick();
        checks++; if (bus.fetch_valid !== 1'b1 || bus.pc !== 32'h0) begin errors++; $display("FAIL run0 got fv=%b pc=%h exp fv=1 pc=0", bus.fetch_valid, bus.pc); end
        tick();
        checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL run4 got %h exp 4", bus.pc); end
        tick();
        checks++; if (bus.pc !== 32'h8) begin errors++; $display("FAIL run8 got %h exp 8", bus.pc); end
    endtask

    task automatic test_beq_taken();
        drive(1'b1, 3'd1, 32'h20, 32'hFFFF_FFF0, 32'h0, 2'b00);
        checks++; if (bus.if_id_flush !== 1'b1 || bus.exc !== 1'b0) begin errors++; $display("FAIL beq_flush got %b exc %b exp 1 0", bus.if_id_flush, bus.exc); end
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 2'b00);
        checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL beq_pc got %h exp 10", bus.pc); end
        checks++; if (bus.redir_cnt !== 4'd1) begin errors++; $display("FAIL beq_cnt got %0d exp 1", bus.redir_cnt); end
    endtask

    task automatic test_blt_bge();
        drive(1'b1, 3'd3, 32'h40, 32'h8, 32'h0, 2'b10);
        checks++; if (bus.if_id_flush !== 1'b0) begin errors++; $display("FAIL blt_flush got %b exp 0", bus.if_id_flush); end
        tick();
        checks++; if (bus.pc !== 32'h14) begin errors++; $display("FAIL blt_pc got %h exp 14", bus.pc); end
        drive(1'b1, 3'd4, 32'h40, 32'h8, 32'h0, 2'b10);
        checks++; if (bus.if_id_flush !== 1'b1) begin errors++; $display("FAIL bge_flush got %b exp 1", bus.if_id_flush); end
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 2'b00);
        checks++; if (bus.pc !== 32'h48 || bus.redir_cnt !== 4'd2) begin errors++; $display("FAIL bge_pc got %h cnt %0d exp 48 2", bus.pc, bus.redir_cnt); end
    endtask

    task automatic test_jalr_trap();
        drive(1'b1, 3'd6, 32'h50, 32'h0, 32'h101, 2'b11);
        checks++; if (bus.if_id_flush !== 1'b1 || bus.exc !== 1'b0) begin errors++; $display("FAIL jalr_comb got flush %b exc %b exp 1 0", bus.if_id_flush, bus.exc); end
        tick();
        checks++; if (bus.pc !== 32'h100 || bus.redir_cnt !== 4'd3) begin errors++; $display("FAIL jalr_pc got %h cnt %0d exp 100 3", bus.pc, bus.redir_cnt); end
        drive(1'b1, 3'd5, 32'h80, 32'h2, 32'h0, 2'b00);
        checks++; if (bus.exc !== 1'b1 || bus.if_id_flush !== 1'b1) begin errors++; $display("FAIL jal_exc got exc %b flush %b exp 1 1", bus.exc, bus.if_id_flush); end
        tick();
        // TRAP cycle: a taken jump presented now must not resolve
        drive(1'b1, 3'd5, 32'h90, 32'h8, 32'h0, 2'b00);
        checks++; if (bus.pc !== 32'h100 || bus.epc !== 32'h80) begin errors++; $display("FAIL trap_pc got pc %h epc %h exp 100 80", bus.pc, bus.epc); end
        checks++; if (bus.fetch_valid !== 1'b1 || bus.if_id_flush !== 1'b0 || bus.exc !== 1'b0) begin errors++; $display("FAIL trap_sup got fv %b flush %b exc %b exp 1 0 0", bus.fetch_valid, bus.if_id_flush, bus.exc); end
        checks++; if (bus.redir_cnt !== 4'd3) begin errors++; $display("FAIL trap_cnt got %0d exp 3", bus.redir_cnt); end
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 2'b00);
        checks++; if (bus.pc !== 32'h104) begin errors++; $display("FAIL trap_exit got %h exp 104", bus.pc); end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        drive(1'b1, 3'd2, 32'h200, 32'h10, 32'h0, 2'b10);
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.if_id_flush !== 1'b0 || bus.exc !== 1'b0) begin errors++; $display("FAIL stall_flush%0d got %b %b exp 0 0", i, bus.if_id_flush, bus.exc); end
            tick();
            checks++; if (bus.pc !== 32'h104) begin errors++; $display("FAIL stall_pc%0d got %h exp 104", i, bus.pc); end
        end
        bus.stall = 1'b0;
        #1;
        checks++; if (bus.if_id_flush !== 1'b1) begin errors++; $display("FAIL unstall_flush got %b exp 1", bus.if_id_flush); end
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 2'b00);
        checks++; if (bus.pc !== 32'h210 || bus.redir_cnt !== 4'd4) begin errors++; $display("FAIL unstall_pc got %h cnt %0d exp 210 4", bus.pc, bus.redir_cnt); end
    endtask

    task automatic test_wrap_counter();
        drive(1'b1, 3'd5, 32'h0, 32'hFFFF_FFF8, 32'h0, 2'b00);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 2'b00);
        checks++; if (bus.pc !== 32'hFFFF_FFF8 || bus.redir_cnt !== 4'd5) begin errors++; $display("FAIL wrap_jal got %h cnt %0d exp fffffff8 5", bus.pc, bus.redir_cnt); end
        tick();
        checks++; if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fc got %h exp fffffffc", bus.pc); end
        tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_0 got %h exp 0", bus.pc); end
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 3'd1, 32'h1000 + 32'(i) * 32'h10, 32'h0, 32'h0, 2'b00);
            tick();
            if (i == 9) begin
                checks++; if (bus.redir_cnt !== 4'd15) begin errors++; $display("FAIL cnt15 got %0d exp 15", bus.redir_cnt); end
            end
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 2'b00);
        checks++; if (bus.redir_cnt !== 4'd0 || bus.pc !== 32'h10A0) begin errors++; $display("FAIL cnt_wrap got cnt %0d pc %h exp 0 10a0", bus.redir_cnt, bus.pc); end
    endtask

    task automatic test_reset_mid_redirect();
        drive(1'b1, 3'd5, 32'h300, 32'h3, 32'h0, 2'b00);
        checks++; if (bus.exc !== 1'b1) begin errors++; $display("FAIL mid_exc_pre got %b exp 1", bus.exc); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.pc !== 32'h0 || bus.redir_cnt !== 4'd0 || bus.epc !== 32'h0) begin errors++; $display("FAIL mid_reset got pc %h cnt %0d epc %h exp 0 0 0", bus.pc, bus.redir_cnt, bus.epc); end
        checks++; if (bus.if_id_flush !== 1'b0 || bus.exc !== 1'b0 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out got %b%b%b exp 000", bus.if_id_flush, bus.exc, bus.fetch_valid); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.pc !== 32'h0 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL mid_boot got pc %h fv %b exp 0 1", bus.pc, bus.fetch_valid); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.stall      = 1'b0;
        bus.id_valid   = 1'b0;
        bus.id_br_type = 3'd0;
        bus.id_pc      = 32'h0;
        bus.id_imm     = 32'h0;
        bus.id_rs1     = 32'h0;
        bus.branch     = 2'b00;
        test_reset();
        test_beq_taken();
        test_blt_bge();
        test_jalr_trap();
        test_stall();
        test_wrap_counter();
        test_reset_mid_redirect();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
